// File: rtl/m_float2fix_pipe.sv
// m_float2fix_pipe
// Pipelined IEEE-754 single-precision to signed fixed-point converter.
// Each beat carries LANES floats. The result is two's complement OUT_W bits
// wide with FRAC_BITS fractional bits. A lane can truncate toward zero or
// round to nearest even, and it clamps to the output range when needed.
//
// Ports
//   clk, rstn              clock (rising edge), asynchronous active-low reset
//   src_valid/src_ready    input handshake; src_ready = !stall
//   rnd_mode               0 = truncate, 1 = round-to-nearest-even (per beat)
//   src_data               LANES packed floats, lane i at [32i+31:32i]
//   dst_valid/dst_ready    output handshake; global stall when !dst_ready
//   dst_data               LANES packed fixed results, lane i at [OUT_W*i +: OUT_W]
//   dst_sat                per-lane flag: clamped, or the input was NaN/Inf
//
// Optional build macro M_FLOAT2FIX_PIPE_STATS_EN adds:
//   sat_cnt_clr            synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt[15:0]          saturating count of dst_sat bits over transferred beats

module m_float2fix_pipe #(
    parameter int LANES     = 8,
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic                   rnd_mode,
    input  logic [LANES*32-1:0]    src_data,
    output logic                   dst_valid,
    input  logic                   dst_ready,
    output logic [LANES*OUT_W-1:0] dst_data,
    output logic [LANES-1:0]       dst_sat
`ifdef M_FLOAT2FIX_PIPE_STATS_EN
    ,
    input  logic                   sat_cnt_clr,
    output logic [15:0]            sat_cnt
`endif
);

    // A 24-bit mantissa shifted left by up to 31 still fits in 56 bits.
    localparam int MAG_W = 56;
    localparam logic [OUT_W-1:0] MAX_VAL = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_VAL = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [MAG_W-1:0] LIM_POS = MAG_W'(MAX_VAL);
    localparam logic [MAG_W-1:0] LIM_NEG = MAG_W'(MIN_VAL);
    localparam logic signed [9:0] SH_BIAS = 10'(FRAC_BITS - 150);
    localparam logic signed [9:0] SH_MAX  = 10'(OUT_W);

    // Align the mantissa, then round the magnitude (sign is applied later).
    function automatic logic [MAG_W-1:0] round_mag(input logic [23:0] man, input logic lsh,
                                                   input logic under, input logic [4:0] amt,
                                                   input logic rne);
        logic [23:0] kept;
        logic [23:0] below;
        logic        guard;
        logic        inc;
        logic [24:0] rounded;
        kept      = man >> amt;
        guard     = man[amt - 5'd1];
        below     = man & ((24'd1 << (amt - 5'd1)) - 24'd1);
        inc       = rne && guard && ((|below) || kept[0]);
        rounded   = {1'b0, kept} + {24'd0, inc};
        round_mag = '0;
        if (under)    round_mag = '0;
        else if (lsh) round_mag = MAG_W'(man) << amt;
        else          round_mag = MAG_W'(rounded);
    endfunction

    // Apply the sign and clamp. Returns {sat, value}.
    function automatic logic [OUT_W:0] saturate(input logic sign, input logic nan, input logic big,
                                                input logic [MAG_W-1:0] mag);
        logic signed [OUT_W-1:0] neg;
        neg = ~mag[OUT_W-1:0] + OUT_W'(1);
        if (nan)             saturate = {1'b1, {OUT_W{1'b0}}};
        else if (big)        saturate = {1'b1, sign ? MIN_VAL : MAX_VAL};
        else if (!sign)      saturate = (mag > LIM_POS) ? {1'b1, MAX_VAL} : {1'b0, mag[OUT_W-1:0]};
        else                 saturate = (mag > LIM_NEG) ? {1'b1, MIN_VAL} : {1'b0, neg};
    endfunction

    logic advance;
    logic vld_p1, vld_p2;

    // Global stall: every stage holds while the output beat waits.
    assign advance   = !(dst_valid && !dst_ready);
    assign src_ready = advance;

    // S1 combinational: unpack, classify, shift amount
    logic [7:0]        exp_c   [LANES];
    logic signed [9:0] sh_c    [LANES];
    logic [23:0]       man_c   [LANES];
    logic [4:0]        amt_c   [LANES];
    logic [LANES-1:0]  sign_c, nan_c, big_c, under_c, lsh_c;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            exp_c[i]   = src_data[32*i+23 +: 8];
            sh_c[i]    = $signed({2'b00, exp_c[i]}) + SH_BIAS;
            man_c[i]   = {1'b1, src_data[32*i +: 23]};
            sign_c[i]  = src_data[32*i+31];
            nan_c[i]   = (exp_c[i] == 8'hFF) && (src_data[32*i +: 23] != 23'd0);
            // Inf, and left shifts that would push the leading one past the sign bit
            big_c[i]   = (exp_c[i] == 8'hFF) || (sh_c[i] >= SH_MAX);
            lsh_c[i]   = !sh_c[i][9];
            // Zero/denormal, or right shifts so deep that only sticky remains
            under_c[i] = (exp_c[i] == 8'd0) || (sh_c[i] <= -10'sd25);
            amt_c[i]   = lsh_c[i] ? sh_c[i][4:0] : 5'(-sh_c[i]);
        end
    end

    // S1 -> S2 boundary
    logic [23:0]      man_p1 [LANES];
    logic [4:0]       amt_p1 [LANES];
    logic [LANES-1:0] sign_p1, nan_p1, big_p1, under_p1, lsh_p1;
    logic             rne_p1;

    always_ff @(posedge clk) begin
        if (advance && src_valid) begin
            man_p1   <= man_c;
            amt_p1   <= amt_c;
            sign_p1  <= sign_c;
            nan_p1   <= nan_c;
            big_p1   <= big_c;
            under_p1 <= under_c;
            lsh_p1   <= lsh_c;
            rne_p1   <= rnd_mode;
        end
    end

    // S2 combinational: align and round the magnitude
    logic [MAG_W-1:0] mag_c [LANES];

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mag_c[i] = round_mag(man_p1[i], lsh_p1[i], under_p1[i], amt_p1[i], rne_p1);
        end
    end

    // S2 -> S3 boundary
    logic [MAG_W-1:0] mag_p2 [LANES];
    logic [LANES-1:0] sign_p2, nan_p2, big_p2;

    always_ff @(posedge clk) begin
        if (advance && vld_p1) begin
            mag_p2  <= mag_c;
            sign_p2 <= sign_p1;
            nan_p2  <= nan_p1;
            big_p2  <= big_p1;
        end
    end

    // S3 combinational: negate and saturate
    logic [OUT_W:0]         res_c [LANES];
    logic [LANES*OUT_W-1:0] data_c;
    logic [LANES-1:0]       sat_c;

    always_comb begin
        data_c = '0;
        sat_c  = '0;
        for (int i = 0; i < LANES; i++) begin
            res_c[i]                 = saturate(sign_p2[i], nan_p2[i], big_p2[i], mag_p2[i]);
            data_c[OUT_W*i +: OUT_W] = res_c[i][OUT_W-1:0];
            sat_c[i]                 = res_c[i][OUT_W];
        end
    end

    // Stage valids and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            dst_valid <= 1'b0;
            dst_data  <= '0;
            dst_sat   <= '0;
        end else if (advance) begin
            vld_p1    <= src_valid;
            vld_p2    <= vld_p1;
            dst_valid <= vld_p2;
            if (vld_p2) begin
                dst_data <= data_c;
                dst_sat  <= sat_c;
            end
        end
    end

`ifdef M_FLOAT2FIX_PIPE_STATS_EN
    logic [16:0] sat_sum;

    always_comb begin
        sat_sum = {1'b0, sat_cnt};
        for (int i = 0; i < LANES; i++) begin
            sat_sum = sat_sum + {16'd0, dst_sat[i]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt <= 16'd0;
        end else if (sat_cnt_clr) begin
            sat_cnt <= 16'd0;
        end else if (dst_valid && dst_ready) begin
            sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_m_float2fix_pipe.sv
// Testbench for m_float2fix_pipe (LANES=8, OUT_W=32, FRAC_BITS=16).
// Reference model converts each float with real arithmetic and an
// exact integer/fraction split, independent of the shift datapath.

module tb_m_float2fix_pipe;

    localparam int LANES = 8;
    localparam int OUT_W = 32;
    localparam int FRAC  = 16;
    localparam int DW    = LANES * 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          src_valid;
    logic          src_ready;
    logic          rnd_mode;
    logic [DW-1:0] src_data;
    logic          dst_valid;
    logic          dst_ready;
    logic [DW-1:0] dst_data;
    logic [7:0]    dst_sat;
`ifdef M_FLOAT2FIX_PIPE_STATS_EN
    logic          sat_cnt_clr;
    logic [15:0]   sat_cnt;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [7:0]    s;
    } beat_t;

    beat_t exp_q[$];

    m_float2fix_pipe #(.LANES(LANES), .OUT_W(OUT_W), .FRAC_BITS(FRAC)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .rnd_mode  (rnd_mode),
        .src_data  (src_data),
        .dst_valid (dst_valid),
        .dst_ready (dst_ready),
        .dst_data  (dst_data),
        .dst_sat   (dst_sat)
`ifdef M_FLOAT2FIX_PIPE_STATS_EN
        ,
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real pow2(input int p);
        real r;
        r = 1.0;
        if (p >= 0) for (int k = 0; k < p; k++) r = r * 2.0;
        else        for (int k = 0; k < -p; k++) r = r / 2.0;
        return r;
    endfunction

    function automatic void model_lane(input logic [31:0] f, input logic rne,
                                       output logic [31:0] val, output logic sat);
        int     e;
        real    r, fr;
        longint ip, v;
        e   = int'(f[30:23]);
        val = 32'd0;
        sat = 1'b0;
        if (e == 255) begin
            sat = 1'b1;
            if (f[22:0] == 23'd0) val = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            return;
        end
        if (e == 0) return;
        r = real'({1'b1, f[22:0]}) * pow2(e - 150 + FRAC);
        if (r >= pow2(40)) begin
            val = f[31] ? 32'h80000000 : 32'h7FFFFFFF;
            sat = 1'b1;
            return;
        end
        ip = longint'(r);
        if (real'(ip) > r) ip = ip - 1;
        fr = r - real'(ip);
        if (rne && (fr > 0.5 || (fr == 0.5 && ip[0]))) ip = ip + 1;
        v = f[31] ? -ip : ip;
        if (v > 64'sd2147483647) begin
            val = 32'h7FFFFFFF;
            sat = 1'b1;
        end else if (v < -64'sd2147483648) begin
            val = 32'h80000000;
            sat = 1'b1;
        end else begin
            val = v[31:0];
        end
    endfunction

    function automatic void model_beat(input logic [DW-1:0] d, input logic rne,
                                       output logic [DW-1:0] ed, output logic [7:0] es);
        logic [31:0] v;
        logic        s;
        ed = '0;
        es = '0;
        for (int i = 0; i < LANES; i++) begin
            model_lane(d[32*i +: 32], rne, v, s);
            ed[32*i +: 32] = v;
            es[i]          = s;
        end
    endfunction

    function automatic logic [31:0] rand_float();
        logic [31:0] f;
        int          k;
        k        = int'($urandom_range(0, 15));
        f[31]    = 1'($urandom);
        f[22:0]  = 23'($urandom);
        if (k == 0)      f[30:23] = 8'd0;
        else if (k == 1) f[30:23] = 8'hFF;
        else             f[30:23] = 8'($urandom_range(100, 160));
        if (k == 2) f[15:0] = 16'h8000;
        return f;
    endfunction

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        for (int i = 0; i < LANES; i++) d[32*i +: 32] = rand_float();
        return d;
    endfunction

    // Present one beat, confirm the 3-cycle latency and compare with the model.
    // Leaves the bench in the cycle where the result is on dst (dst_ready=1).
    task automatic run_beat(input logic [DW-1:0] d, input logic rne,
                            output logic [DW-1:0] od, output logic [7:0] os);
        logic [DW-1:0] ed;
        logic [7:0]    es;
        model_beat(d, rne, ed, es);
        src_data  = d;
        rnd_mode  = rne;
        src_valid = 1'b1;
        dst_ready = 1'b1;
        #1;
        check("accept_ready", DW'(src_ready), DW'(1));
        tick();
        src_valid = 1'b0;
        rnd_mode  = ~rne;
        check("latency_c1", DW'(dst_valid), DW'(0));
        tick();
        check("latency_c2", DW'(dst_valid), DW'(0));
        tick();
        check("latency_c3", DW'(dst_valid), DW'(1));
        od = dst_data;
        os = dst_sat;
        check("beat_data", od, ed);
        check("beat_sat", DW'(os), DW'(es));
    endtask

    logic [DW-1:0] d, od, prev_data;
    logic [7:0]    os, prev_sat;
    logic [DW-1:0] bp_beats [10];
    logic          bp_mode  [10];
    beat_t         b;
    int            sent, recv, cyc;
    logic          stall, prev_stall;

    initial begin
        rstn      = 1'b0;
        src_valid = 1'b0;
        rnd_mode  = 1'b0;
        src_data  = '0;
        dst_ready = 1'b1;
`ifdef M_FLOAT2FIX_PIPE_STATS_EN
        sat_cnt_clr = 1'b0;
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_dst_valid", DW'(dst_valid), DW'(0));
        check("rst_dst_data", dst_data, DW'(0));
        check("rst_dst_sat", DW'(dst_sat), DW'(0));
`ifdef M_FLOAT2FIX_PIPE_STATS_EN
        check("rst_sat_cnt", DW'(sat_cnt), DW'(0));
`endif
        rstn = 1'b1;
        #1;
        check("rst_src_ready", DW'(src_ready), DW'(1));
        tick();

        // Basic latency: 1.0 and -2.5
        d = rand_beat();
        d[31:0]  = 32'h3F800000;
        d[63:32] = 32'hC0200000;
        run_beat(d, 1'b1, od, os);
        check("basic_l0", DW'(od[31:0]), DW'(32'h00010000));
        check("basic_l1", DW'(od[63:32]), DW'(32'hFFFD8000));
        check("basic_sat", DW'(os[1:0]), DW'(0));
        tick();

        // Rounding: 1.5 LSB and 0.5 LSB in both modes
        d = rand_beat();
        d[31:0]  = 32'h37C00000;
        d[63:32] = 32'h37000000;
        run_beat(d, 1'b1, od, os);
        check("rne_1p5", DW'(od[31:0]), DW'(2));
        check("rne_0p5", DW'(od[63:32]), DW'(0));
        tick();
        run_beat(d, 1'b0, od, os);
        check("trunc_1p5", DW'(od[31:0]), DW'(1));
        check("trunc_0p5", DW'(od[63:32]), DW'(0));
        tick();

        // Saturation and special values
        d = rand_beat();
        d[31:0]    = 32'h47800000;
        d[63:32]   = 32'hC7000000;
        d[95:64]   = 32'h7FC00000;
        d[127:96]  = 32'hFF800000;
        d[159:128] = 32'h80000000;
        run_beat(d, 1'b0, od, os);
        check("sat_pos_big", DW'(od[31:0]), DW'(32'h7FFFFFFF));
        check("min_exact", DW'(od[63:32]), DW'(32'h80000000));
        check("nan_val", DW'(od[95:64]), DW'(0));
        check("ninf_val", DW'(od[127:96]), DW'(32'h80000000));
        check("nzero_val", DW'(od[159:128]), DW'(0));
        check("special_sat", DW'(os[4:0]), DW'(5'b01101));
        tick();

        // Randomized beats against the model
        for (int j = 0; j < 24; j++) begin
            run_beat(rand_beat(), 1'($urandom), od, os);
            tick();
        end

        // Backpressure with dst_ready pattern 1,0,0,1
        for (int j = 0; j < 10; j++) begin
            bp_beats[j]        = rand_beat();
            bp_beats[j][31:0]  = 32'h3F800000 + (32'(j) << 20);
            bp_mode[j]         = 1'($urandom);
        end
        sent = 0;
        recv = 0;
        cyc  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_sat   = '0;
        while (recv < 10 && cyc < 200) begin
            dst_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            src_valid = (sent < 10);
            src_data  = bp_beats[(sent < 10) ? sent : 0];
            rnd_mode  = bp_mode[(sent < 10) ? sent : 0];
            #1;
            stall = dst_valid && !dst_ready;
            check("bp_src_ready", DW'(src_ready), DW'(!stall));
            if (prev_stall) begin
                check("bp_hold_valid", DW'(dst_valid), DW'(1));
                check("bp_hold_data", dst_data, prev_data);
                check("bp_hold_sat", DW'(dst_sat), DW'(prev_sat));
            end
            if (dst_valid && dst_ready) begin
                check("bp_beat_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("bp_data", dst_data, b.d);
                    check("bp_sat", DW'(dst_sat), DW'(b.s));
                    recv++;
                end
            end
            if (src_valid && src_ready) begin
                model_beat(bp_beats[sent], bp_mode[sent], b.d, b.s);
                exp_q.push_back(b);
                sent++;
            end
            prev_stall = stall;
            prev_data  = dst_data;
            prev_sat   = dst_sat;
            tick();
            cyc++;
        end
        src_valid = 1'b0;
        dst_ready = 1'b1;
        check("bp_sent", DW'(sent), DW'(10));
        check("bp_recv", DW'(recv), DW'(10));
        for (int j = 0; j < 5; j++) begin
            check("bp_no_dup", DW'(dst_valid), DW'(0));
            tick();
        end

        // Reset while two beats are in flight
        src_data  = rand_beat();
        src_valid = 1'b1;
        tick();
        src_data  = rand_beat();
        tick();
        src_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        check("midrst_valid", DW'(dst_valid), DW'(0));
        tick();
        rstn = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("midrst_no_beat", DW'(dst_valid), DW'(0));
            check("midrst_ready", DW'(src_ready), DW'(1));
            tick();
        end

`ifdef M_FLOAT2FIX_PIPE_STATS_EN
        // Saturation counter: 3 beats x 2 NaN lanes, then clear with a 4th
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        check("stats_cleared", DW'(sat_cnt), DW'(0));
        d = '0;
        d[31:0]  = 32'h7FC00000;
        d[95:64] = 32'hFFC00001;
        for (int j = 0; j < 3; j++) begin
            run_beat(d, 1'b1, od, os);
            tick();
        end
        check("stats_six", DW'(sat_cnt), DW'(6));
        run_beat(d, 1'b1, od, os);
        sat_cnt_clr = 1'b1;
        tick();
        sat_cnt_clr = 1'b0;
        check("stats_clr_priority", DW'(sat_cnt), DW'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
